// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared byte width and sequencer state encodings for the spi burst sequencer
package spi_pkg;
    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_KICK      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_STORE     = 3'd4
    } seq_state_t;
endpackage

// File: rtl/spi_byte_fifo.sv
// rtl/spi_byte_fifo.sv - synchronous show-ahead byte FIFO, full/empty from extra pointer MSB
module spi_byte_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [SPI_BYTE_W-1:0] wdata,
    output logic                  full,
    input  logic                  rd,
    output logic [SPI_BYTE_W-1:0] rdata,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [SPI_BYTE_W-1:0] mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = rd && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = wr && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/spi_burst_seq.sv
// rtl/spi_burst_seq.sv - queues multi-byte SPI bursts through the byte-wide spi core
// Optional SPI_BURST_IRQ_EN adds a sticky irq output with irq_clr input.
module spi_burst_seq
    import spi_pkg::*;
#(
    parameter int                    FIFO_DEPTH = 8,
    parameter int                    LEN_W      = 8,
    parameter logic [SPI_BYTE_W-1:0] FILL_BYTE  = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    input  logic                  tx_wr,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    output logic                  tx_full,
    input  logic                  rx_rd,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_empty,
    output logic                  active,
    output logic                  done,
    output logic                  overrun,
    output logic [SPI_BYTE_W-1:0] spi_data_in,
    output logic                  spi_ready_send,
    input  logic                  spi_busy,
    input  logic [SPI_BYTE_W-1:0] spi_data_out
`ifdef SPI_BURST_IRQ_EN
    ,
    output logic                  irq,
    input  logic                  irq_clr
`endif
);
    seq_state_t            state;
    seq_state_t            next_state;
    logic [LEN_W-1:0]      remaining;
    logic                  tx_empty;
    logic [SPI_BYTE_W-1:0] tx_head;
    logic                  tx_pop;
    logic                  rx_push;
    logic                  rx_full;
    logic                  accept;
    logic                  overrun_set;

    assign accept      = (state == ST_IDLE) && start && (len != '0);
    assign tx_pop      = (state == ST_LOAD) && !tx_empty;
    assign rx_push     = (state == ST_STORE);
    assign overrun_set = rx_push && rx_full && !rx_rd;
    assign active      = (state != ST_IDLE);

    spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (tx_wr),
        .wdata (tx_data),
        .full  (tx_full),
        .rd    (tx_pop),
        .rdata (tx_head),
        .empty (tx_empty)
    );

    spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (rx_push),
        .wdata (spi_data_out),
        .full  (rx_full),
        .rd    (rx_rd),
        .rdata (rx_data),
        .empty (rx_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            overrun     <= 1'b0;
            spi_data_in <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                remaining <= len;
                overrun   <= 1'b0;
            end
            if (state == ST_LOAD) spi_data_in <= tx_empty ? FILL_BYTE : tx_head;
            if (rx_push) remaining <= remaining - LEN_W'(1);
            if (overrun_set) overrun <= 1'b1;
        end
    end

    always_comb begin
        next_state     = state;
        spi_ready_send = 1'b0;
        done           = 1'b0;
        case (state)
            ST_IDLE:      if (accept) next_state = ST_LOAD;
            ST_LOAD:      next_state = ST_KICK;
            ST_KICK: begin
                spi_ready_send = 1'b1;
                if (spi_busy) next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: if (!spi_busy) next_state = ST_STORE;
            ST_STORE: begin
                if (remaining == LEN_W'(1)) begin
                    next_state = ST_IDLE;
                    done       = 1'b1;
                end else begin
                    next_state = ST_LOAD;
                end
            end
            default:      next_state = ST_IDLE;
        endcase
    end

`ifdef SPI_BURST_IRQ_EN
    // Set takes priority so a clear racing a new event cannot lose it.
    always_ff @(posedge clk) begin
        if (rst)                              irq <= 1'b0;
        else if (done || (overrun_set && !overrun)) irq <= 1'b1;
        else if (irq_clr)                     irq <= 1'b0;
    end
`endif
endmodule
